// File: rtl/pipelined_aoi_unit.sv
// pipelined_aoi_unit: two-stage AND-OR-INVERT with valid/ready handshake and a saturating count of true results.
// Optional macro AOI_OAI_MODE_EN adds a per-item mode input that selects OR-AND-INVERT.
module pipelined_aoi_unit #(
    parameter int unsigned GROUPS = 2,
    parameter int unsigned TERM_W = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [GROUPS*TERM_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
`ifdef AOI_OAI_MODE_EN
    input  logic                     mode,
`endif
    output logic [GROUPS-1:0]        term_out,
    output logic                     aoi_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         true_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              s1_valid;
    logic [GROUPS-1:0] s1_terms;
    logic              s1_mode;
    logic [GROUPS-1:0] in_terms_c;
    logic              in_mode_c;
    logic              s2_adv_c;
    logic              s1_load_c;
    logic              s2_aoi_c;

    // Stage 2 frees up when empty or draining; stage 1 when empty or stage 2 takes its item.
    assign s2_adv_c  = !out_valid || out_ready;
    assign s1_load_c = !s1_valid || s2_adv_c;
    assign in_ready  = s1_load_c;

`ifdef AOI_OAI_MODE_EN
    assign in_mode_c = mode;
`else
    assign in_mode_c = 1'b0;
`endif

    // Per-term reduction of the incoming slices (AND, or OR in OAI mode).
    always_comb begin
        in_terms_c = '0;
        for (int g = 0; g < int'(GROUPS); g++) begin
            if (in_mode_c) begin
                in_terms_c[g] = |in_data[g*TERM_W +: TERM_W];
            end else begin
                in_terms_c[g] = &in_data[g*TERM_W +: TERM_W];
            end
        end
    end

    // Final inversion of the combined terms for stage 2.
    always_comb begin
        s2_aoi_c = ~(|s1_terms);
        if (s1_mode) begin
            s2_aoi_c = ~(&s1_terms);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_terms <= '0;
            s1_mode  <= 1'b0;
        end else if (s1_load_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_terms <= in_terms_c;
                s1_mode  <= in_mode_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            term_out  <= '0;
            aoi_out   <= 1'b0;
        end else if (s2_adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                term_out <= s1_terms;
                aoi_out  <= s2_aoi_c;
            end
        end
    end

    // Count delivered results with aoi_out high, holding at the maximum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            true_count <= '0;
        end else if (out_valid && out_ready && aoi_out && (true_count != CNT_MAX)) begin
            true_count <= true_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipelined_aoi_unit.md
PIPELINED_AOI_UNIT -- requirements
Module: pipelined_aoi_unit

Interface
REQ-001 The module SHALL have parameter GROUPS, default 2, giving the number of AND terms (legal range 1..8).
REQ-002 The module SHALL have parameter TERM_W, default 2, giving the number of inputs per AND term (legal range 1..8).
REQ-003 The module SHALL have parameter CNT_W, default 16, giving the width of the result counter.
REQ-004 Port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port in_data: input, GROUPS*TERM_W bits; term g uses bits [g*TERM_W +: TERM_W].
REQ-007 Port in_valid: input, 1 bit, in_data is valid this cycle.
REQ-008 Port in_ready: output, 1 bit, the block accepts in_data this cycle.
REQ-009 Port term_out: output, GROUPS bits, registered per-term results aligned with aoi_out.
REQ-010 Port aoi_out: output, 1 bit, registered inverted OR of all terms.
REQ-011 Port out_valid: output, 1 bit, term_out and aoi_out are valid.
REQ-012 Port out_ready: input, 1 bit, downstream accepts the output this cycle.
REQ-013 Port true_count: output, CNT_W bits, number of delivered results with aoi_out=1.

Function
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-015 Stage 1 SHALL register the AND reduction of each TERM_W slice together with a stage-1 valid bit.
REQ-016 Stage 2 SHALL register term_out as a copy of the stage-1 terms and aoi_out as NOT(OR of the stage-1 terms), together with out_valid.
REQ-017 Latency from input transfer to out_valid=1 SHALL be exactly 2 cycles when out_ready is held at 1.
REQ-018 Throughput SHALL be one transfer per cycle with no bubbles while out_ready=1.
REQ-019 Stage 2 SHALL load when out_valid=0 or out_ready=1 (s2_adv); otherwise it SHALL hold its contents.
REQ-020 Stage 1 SHALL load when stage 1 is empty or s2_adv=1; in_ready SHALL equal that condition, computed combinationally without depending on in_valid.
REQ-021 Under backpressure (out_ready=0) the block SHALL hold at most 2 items, lose none, and deliver them in order.
REQ-022 When a stage advances with no incoming item, its valid bit SHALL clear.
REQ-023 true_count SHALL increment by 1 on each output transfer with aoi_out=1.
REQ-024 true_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 With GROUPS=1, aoi_out SHALL equal the NAND of the term; with TERM_W=1, each term SHALL pass its bit through.

Reset
REQ-026 While reset_n=0, the stage-1 valid bit, out_valid, term_out, aoi_out and true_count SHALL be 0 asynchronously.
REQ-027 Asserting reset mid-operation SHALL discard all in-flight items, with no partial output.
REQ-028 in_ready SHALL be 1 in the first cycle after reset_n deasserts.

Configuration
REQ-029 With macro AOI_OAI_MODE_EN defined, the module SHALL add input port mode (1 bit).
REQ-030 mode SHALL be captured with in_data into stage 1; mode=0 SHALL select AOI, and mode=1 SHALL select OAI (per term OR-reduce, aoi_out=NOT(AND of terms)).
REQ-031 With AOI_OAI_MODE_EN undefined, the mode port SHALL be absent and behaviour SHALL be AOI only.
REQ-032 With AOI_OAI_MODE_EN defined, true_count SHALL count aoi_out=1 results in either mode.

Verification
REQ-033 Default parameters, out_ready=1: apply in_data 4'b0000, 4'b0011, 4'b1100, 4'b0101 on consecutive cycles -> outputs on cycles 2..5 are (term_out, aoi_out) = (00,1), (01,0), (10,0), (00,1), and true_count=2.
REQ-034 Backpressure: with out_ready=0, stream 3 items -> in_ready=0 after 2 accepted; raise out_ready -> all 3 items delivered in order, none duplicated.
REQ-035 Saturation: CNT_W=2, deliver 5 results with aoi_out=1 -> true_count reads 1, 2, 3, 3, 3.
REQ-036 Reset mid-stream: assert reset_n=0 with 2 items in flight -> out_valid=0 immediately; after release, no stale output appears.
REQ-037 GROUPS=3, TERM_W=4: in_data 12'hF00 -> term_out=3'b100, aoi_out=0; in_data 12'hEEE -> term_out=000, aoi_out=1.
REQ-038 AOI_OAI_MODE_EN defined, mode=1: in_data 4'b0100 -> term_out=2'b10, aoi_out=1; in_data 4'b0110 -> term_out=11, aoi_out=0.
